rv32i_writeback: RTL and testbench

Writeback stage for the RV32I core: sits directly upstream of the register file and drives its single write port. Accepts completed ALU results and load requests from execute via a valid/ready handshake, waits for the load data response, performs byte/halfword extraction and sign/zero extension, and issues one registered write per instruction. Maintains a 32-bit pending-write scoreboard consumed by the hazard/stall logic.

---
 rtl/rv32i_writeback_if.sv | 30 +++
 rtl/rv32i_writeback.sv | 138 +++++++++++++
 tb/tb_rv32i_writeback.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_writeback_if.sv
// Execute-to-writeback handshake plus load-data response bundle.
//   ex_valid/ex_ready : instruction handoff from execute
//   ex_rd, ex_result  : destination register and ALU result
//   ex_is_load, ex_funct3, ex_addr_lo : load descriptor
//   mem_rvalid, mem_rdata, mem_err    : load data response
// master: the side presenting instructions and responses; slave: writeback.
interface rv32i_writeback_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        output mem_rvalid, mem_rdata, mem_err,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        input  mem_rvalid, mem_rdata, mem_err,
        output ex_ready
    );
endinterface

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: accepts ALU results and loads from execute, waits
// for the load response, extracts/extends load data and drives the single
// register-file write port. Keeps a pending-write scoreboard (sb_busy).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wb (slave)      : execute handshake and load response
//   wr_en/addr/data : registered register-file write port
//   sb_busy         : pending-write bitmap, bit 0 always 0
//   load_err        : one-cycle pulse for a faulted or illegal load
//   idle            : no load outstanding and no write in flight
// Optional: define RV32I_WB_FWD_EN to add fwd_valid/fwd_addr/fwd_data, a
// combinational forward of load data in the response cycle; the load's
// scoreboard bit then clears at the response edge.
module rv32i_writeback (
    input  logic               clk,
    input  logic               rst,
    rv32i_writeback_if.slave   wb,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [31:0]        wr_data,
    output logic [31:0]        sb_busy,
    output logic               load_err,
    output logic               idle
`ifdef RV32I_WB_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [4:0]         fwd_addr,
    output logic [31:0]        fwd_data
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  pend_rd;
    logic [2:0]  pend_f3;
    logic [1:0]  pend_addr;
    logic        accept, rsp, rsp_err, legal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] sb_set, sb_clr, sb_next;

    assign wb.ex_ready = (state_q == IDLE);
    assign accept      = wb.ex_valid && (state_q == IDLE);
    assign rsp         = (state_q == WAIT_LOAD) && wb.mem_rvalid;
    assign idle        = (state_q == IDLE) && !wr_en;

    // Load extraction and legality from the captured descriptor.
    always_comb begin
        ld_byte = wb.mem_rdata[{pend_addr, 3'b000} +: 8];
        ld_half = wb.mem_rdata[{pend_addr[1], 4'b0000} +: 16];
        legal   = 1'b0;
        ld_data = '0;
        case (pend_f3)
            3'b000: begin legal = 1'b1;               ld_data = {{24{ld_byte[7]}}, ld_byte};  end
            3'b100: begin legal = 1'b1;               ld_data = {24'b0, ld_byte};             end
            3'b001: begin legal = !pend_addr[0];      ld_data = {{16{ld_half[15]}}, ld_half}; end
            3'b101: begin legal = !pend_addr[0];      ld_data = {16'b0, ld_half};             end
            3'b010: begin legal = (pend_addr == 2'b00); ld_data = wb.mem_rdata;               end
            default: begin legal = 1'b0;              ld_data = '0;                           end
        endcase
        rsp_err = wb.mem_err || !legal;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && wb.ex_is_load) state_d = WAIT_LOAD;
            WAIT_LOAD: if (wb.mem_rvalid)           state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_err  <= 1'b0;
            pend_rd   <= '0;
            pend_f3   <= '0;
            pend_addr <= '0;
        end else begin
            wr_en    <= 1'b0;
            load_err <= 1'b0;
            if (accept && !wb.ex_is_load) begin
                wr_en   <= (wb.ex_rd != 5'd0);
                wr_addr <= wb.ex_rd;
                wr_data <= wb.ex_result;
            end else if (accept) begin
                pend_rd   <= wb.ex_rd;
                pend_f3   <= wb.ex_funct3;
                pend_addr <= wb.ex_addr_lo;
            end
            if (rsp) begin
                if (rsp_err) begin
                    load_err <= 1'b1;
                end else begin
                    wr_en   <= (pend_rd != 5'd0);
                    wr_addr <= pend_rd;
                    wr_data <= ld_data;
                end
            end
        end
    end

    // Clear on completion, then OR in new sets so a same-edge set wins.
    // pend_rd still names the faulted load during the load_err cycle.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (accept && (wb.ex_rd != 5'd0)) sb_set[wb.ex_rd] = 1'b1;
        if (wr_en)                        sb_clr[wr_addr]  = 1'b1;
        if (load_err)                     sb_clr[pend_rd]  = 1'b1;
`ifdef RV32I_WB_FWD_EN
        if (rsp && !rsp_err)              sb_clr[pend_rd]  = 1'b1;
`endif
        sb_next = (sb_busy & ~sb_clr) | sb_set;
    end

    always_ff @(posedge clk) begin
        if (rst) sb_busy <= '0;
        else     sb_busy <= {sb_next[31:1], 1'b0};
    end

`ifdef RV32I_WB_FWD_EN
    assign fwd_valid = rsp && !rsp_err && (pend_rd != 5'd0);
    assign fwd_addr  = pend_rd;
    assign fwd_data  = ld_data;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
module tb_rv32i_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] sb_busy;
    logic        load_err;
    logic        idle;

    rv32i_writeback_if bus();

    rv32i_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sb_busy  (sb_busy),
        .load_err (load_err),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-register count of in-flight instructions, the
    // write/error expected in the coming cycle, and the outstanding load.
    int          cnt[32];
    bit          m_wait;
    bit          exp_wen, exp_err;
    logic [4:0]  exp_addr, err_rd, m_rd;
    logic [31:0] exp_data;
    logic [2:0]  m_f3;
    logic [1:0]  m_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_map();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = (cnt[i] > 0);
        return m;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d, output bit ok);
        logic [31:0] sh = d >> (8 * a);
        ok = 1'b0;
        ref_load = '0;
        case (f3)
            3'd0: begin ok = 1'b1;      ref_load = {{24{sh[7]}}, sh[7:0]};   end
            3'd4: begin ok = 1'b1;      ref_load = {24'b0, sh[7:0]};         end
            3'd1: begin ok = (a[0] == 1'b0); ref_load = {{16{sh[15]}}, sh[15:0]}; end
            3'd5: begin ok = (a[0] == 1'b0); ref_load = {16'b0, sh[15:0]};   end
            3'd2: begin ok = (a == 2'd0); ref_load = d;                      end
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        m_wait  = 1'b0;
        exp_wen = 1'b0;
        exp_err = 1'b0;
    endfunction

    // One clock: check outputs of the current cycle, then drive inputs for
    // the next edge and advance the model across that edge.
    task automatic step(input logic r, input logic v, input logic [4:0] rd,
                        input logic [31:0] res, input logic ld, input logic [2:0] f3,
                        input logic [1:0] a, input logic rv, input logic [31:0] rdat,
                        input logic e);
        bit ok;
        logic [31:0] d;
        @(negedge clk);
        check("wr_en", {31'b0, wr_en}, {31'b0, exp_wen});
        if (exp_wen) begin
            check("wr_addr", {27'b0, wr_addr}, {27'b0, exp_addr});
            check("wr_data", wr_data, exp_data);
        end
        check("load_err", {31'b0, load_err}, {31'b0, exp_err});
        check("ex_ready", {31'b0, bus.ex_ready}, {31'b0, !m_wait});
        check("sb_busy", sb_busy, busy_map());
        check("idle", {31'b0, idle}, {31'b0, (!m_wait && !exp_wen)});

        rst            = r;
        bus.ex_valid   = v;
        bus.ex_rd      = rd;
        bus.ex_result  = res;
        bus.ex_is_load = ld;
        bus.ex_funct3  = f3;
        bus.ex_addr_lo = a;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rdat;
        bus.mem_err    = e;

        if (r) begin
            model_reset();
        end else begin
            if (exp_wen) cnt[exp_addr]--;
            if (exp_err && err_rd != 5'd0) cnt[err_rd]--;
            exp_wen = 1'b0;
            exp_err = 1'b0;
            if (!m_wait && v) begin
                if (rd != 5'd0) cnt[rd]++;
                if (!ld) begin
                    exp_wen  = (rd != 5'd0);
                    exp_addr = rd;
                    exp_data = res;
                end else begin
                    m_wait = 1'b1;
                    m_rd   = rd;
                    m_f3   = f3;
                    m_a    = a;
                end
            end else if (m_wait && rv) begin
                m_wait = 1'b0;
                d = ref_load(m_f3, m_a, rdat, ok);
                if (e || !ok) begin
                    exp_err = 1'b1;
                    err_rd  = m_rd;
                end else begin
                    exp_wen  = (m_rd != 5'd0);
                    exp_addr = m_rd;
                    exp_data = d;
                end
            end
        end
    endtask

    task automatic nop();
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_valid = 0; bus.ex_rd = '0; bus.ex_result = '0; bus.ex_is_load = 0;
        bus.ex_funct3 = '0; bus.ex_addr_lo = '0; bus.mem_rvalid = 0;
        bus.mem_rdata = '0; bus.mem_err = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // ALU write rd=5
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 3'd0, 2'd0, 0, 32'd0, 0);
        nop(); nop();
        // back-to-back rd=1,2,1
        step(0, 1, 5'd1, 32'h11111111, 0, 3'd0, 2'd0, 0, 32'd0, 0);
        step(0, 1, 5'd2, 32'h22222222, 0, 3'd0, 2'd0, 0, 32'd0, 0);
        step(0, 1, 5'd1, 32'h33333333, 0, 3'd0, 2'd0, 0, 32'd0, 0);
        nop(); nop();
        // LB a=3, LHU a=2, LW a=0 on 0x80FF0000 (response after a wait)
        step(0, 1, 5'd7, 32'd0, 1, 3'd0, 2'd3, 0, 32'd0, 0);
        nop();
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h80FF0000, 0);
        step(0, 1, 5'd8, 32'd0, 1, 3'd5, 2'd2, 0, 32'd0, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h80FF0000, 0);
        step(0, 1, 5'd9, 32'd0, 1, 3'd2, 2'd0, 0, 32'd0, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h80FF0000, 0);
        nop();
        // misaligned LH, then bus error on a LW
        step(0, 1, 5'd4, 32'd0, 1, 3'd1, 2'd1, 0, 32'd0, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h12345678, 0);
        nop();
        step(0, 1, 5'd6, 32'd0, 1, 3'd2, 2'd0, 0, 32'd0, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h12345678, 1);
        nop();
        // load to rd=0, stray rvalid while idle
        step(0, 1, 5'd0, 32'd0, 1, 3'd2, 2'd0, 0, 32'd0, 0);
        nop();
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hCAFEF00D, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hCAFEF00D, 0);
        nop();
        // reset during WAIT_LOAD, then a late response
        step(0, 1, 5'd3, 32'd0, 1, 3'd2, 2'd0, 0, 32'd0, 0);
        nop();
        step(1, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0, 0);
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFFFFFF, 0);
        nop(); nop();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 32'($urandom),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0),
                 32'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        // drain: answer any outstanding load, then go quiet
        step(0, 0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h0F0F0F0F, 0);
        repeat (3) nop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
